// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared key-event types for the TM1638 key front end.
// Event word is {kind[1:0], code[2:0]}.
package tm1638_pkg;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_kind_e;

  typedef struct packed {
    ev_kind_e   kind;
    logic [2:0] code;
  } ev_t;

  localparam int EV_W = $bits(ev_t);

endpackage

// File: rtl/tm1638_event_fifo.sv
// tm1638_event_fifo: first-word-fall-through event queue.
// Push while full is ignored unless a pop happens in the same cycle.
module tm1638_event_fifo #(
  parameter int width = 5,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // storage write; contents need no reset, output is gated by empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end

  // read and write pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/tm1638_key_events.sv
// tm1638_key_events: debounce 8 keys, queue PRESS/RELEASE events.
// Define TM1638_KEY_REPEAT_EN to add auto-repeat REPEAT events.
module tm1638_key_events #(
  parameter int clk_mhz         = 27,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys,
  output logic [7:0] key_down,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [4:0] ev_data,
  output logic       overflow,
  input  logic       overflow_clr
);

  import tm1638_pkg::*;

  localparam int TICK_N = clk_mhz * 1000;
  localparam int DW     = $clog2(TICK_N);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_MS - 1);

  logic [DW-1:0]   div_q;
  logic            ms_tick;
  logic [7:0][7:0] cnt_q, cnt_d;
  logic [7:0]      kd_q, kd_d;
  logic [7:0]      tog;
  logic [7:0]      rep_fire;
  logic [7:0]      pend_q, pend_d;
  logic [7:0][1:0] pk_q, pk_d;
  logic [2:0]      sel;
  logic            push;
  ev_t             push_ev;
  logic            ff_full;
  logic            ff_empty;
  logic            pop;
  logic            drop;
  logic            ovf_q;
  logic [EV_W-1:0] ff_dout;

  assign ms_tick = (div_q == DW'(TICK_N - 1));

  // free-running 1 ms divider
  always_ff @(posedge clk) begin
    if (rst)          div_q <= '0;
    else if (ms_tick) div_q <= '0;
    else              div_q <= div_q + 1'b1;
  end

  // per-key debounce: count ms ticks of disagreement
  always_comb begin
    cnt_d = cnt_q;
    kd_d  = kd_q;
    tog   = '0;
    for (int i = 0; i < 8; i++) begin
      if (ms_tick) begin
        if (keys[i] != kd_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            cnt_d[i] = '0;
            kd_d[i]  = ~kd_q[i];
            tog[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

`ifdef TM1638_KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                        REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);

  logic [7:0][RW-1:0] rep_q, rep_d;

  // countdown to next REPEAT while a key stays down
  always_comb begin
    rep_d    = rep_q;
    rep_fire = '0;
    for (int i = 0; i < 8; i++) begin
      if (tog[i]) begin
        rep_d[i] = kd_d[i] ? RW'(REPEAT_DELAY_MS) : '0;
      end else if (ms_tick && kd_q[i]) begin
        if (rep_q[i] == RW'(1)) begin
          rep_fire[i] = 1'b1;
          rep_d[i]    = RW'(REPEAT_RATE_MS);
        end else begin
          rep_d[i] = rep_q[i] - 1'b1;
        end
      end
    end
  end

  // repeat timer state
  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  assign rep_fire = '0;
`endif

  // lowest pending key index wins the single enqueue slot
  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) sel = 3'(i);
    end
  end

  assign push         = |pend_q;
  assign push_ev.kind = ev_kind_e'(pk_q[sel]);
  assign push_ev.code = sel;
  assign pop          = !ff_empty && ev_ready;
  assign drop         = push && ff_full && !pop;

  // pending flags: new toggle overrides any unqueued flag
  always_comb begin
    pend_d = pend_q;
    pk_d   = pk_q;
    if (push) pend_d[sel] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tog[i]) begin
        pend_d[i] = 1'b1;
        pk_d[i]   = kd_d[i] ? EV_PRESS : EV_RELEASE;
      end else if (rep_fire[i]) begin
        pend_d[i] = 1'b1;
        pk_d[i]   = EV_REPEAT;
      end
    end
  end

  // key state, pending events and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      kd_q   <= '0;
      pend_q <= '0;
      pk_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      kd_q   <= kd_d;
      pend_q <= pend_d;
      pk_q   <= pk_d;
      if (drop)              ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  tm1638_event_fifo #(
    .width (EV_W),
    .depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_ev),
    .full  (ff_full),
    .pop   (pop),
    .dout  (ff_dout),
    .empty (ff_empty)
  );

  assign key_down = kd_q;
  assign ev_valid = !ff_empty;
  assign ev_data  = ff_dout;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tm1638_key_events.sv
// tb_tm1638_key_events: vector table, directed corners, random keys
// against a millisecond-level model of debounce and repeat rules.
module tb_tm1638_key_events;

  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys = '0;
  logic [7:0] key_down;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [4:0] ev_data;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  always #5 clk = ~clk;

  tm1638_key_events #(
    .clk_mhz         (1),
    .DEBOUNCE_MS     (DB),
    .REPEAT_DELAY_MS (RD),
    .REPEAT_RATE_MS  (RR),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .keys         (keys),
    .key_down     (key_down),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_data      (ev_data),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit sb_on  = 1'b1;

  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];
  int         got_cyc[$];

  logic [7:0] m_kd;
  int         m_cnt[8];
  int         m_held[8];

  typedef struct {
    logic [7:0] k;
    int         n;
    logic [7:0] kd;
    int         nev;
    logic [4:0] first;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_kd = '0;
    for (int i = 0; i < 8; i++) begin
      m_cnt[i]  = 0;
      m_held[i] = 0;
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    cyc = 0;
  endtask

  // one millisecond of the key rules, keys scanned in index order
  task automatic model_tick(input logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      if (k[i] != m_kd[i]) m_cnt[i]++;
      else                 m_cnt[i] = 0;
      if (m_cnt[i] == DB) begin
        m_cnt[i]  = 0;
        m_kd[i]   = ~m_kd[i];
        m_held[i] = 0;
        exp_q.push_back({m_kd[i] ? 2'b01 : 2'b10, 3'(i)});
      end else if (m_kd[i]) begin
        m_held[i]++;
`ifdef TM1638_KEY_REPEAT_EN
        if (m_held[i] >= RD && (m_held[i] - RD) % RR == 0)
          exp_q.push_back({2'b11, 3'(i)});
`endif
      end
    end
  endtask

  // called at a negedge; advances one clock
  task automatic cycle();
    logic [4:0] e;
    if (ev_valid && ev_ready) begin
      got_q.push_back(ev_data);
      got_cyc.push_back(cyc);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got %b expected none at cycle %0d",
                   ev_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("sb_event", ev_data, e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (cyc % 1000 == 0) model_tick(keys);
    check("key_down", key_down, m_kd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_key_down", key_down, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_data", ev_data, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int base;
    int nrep;
    int rep_c[$];
    int acc;

    tbl[0] = '{8'h01, 4000, 8'h01, 1, 5'b01_000};
    tbl[1] = '{8'h00, 1500, 8'h01, 0, 5'b00_000};
    tbl[2] = '{8'h00, 2000, 8'h00, 1, 5'b10_000};
    tbl[3] = '{8'h04, 1500, 8'h00, 0, 5'b00_000};
    tbl[4] = '{8'h00, 1000, 8'h00, 0, 5'b00_000};
    tbl[5] = '{8'h81, 3500, 8'h81, 2, 5'b01_000};
    tbl[6] = '{8'h00, 3000, 8'h00, 2, 5'b10_000};

    do_reset();

    for (int v = 0; v < 7; v++) begin
      base = got_q.size();
      keys = tbl[v].k;
      if (v == 0) begin
        run(2999);
        check("kd_before_accept", key_down, 0);
        run(tbl[v].n - 2999);
      end else begin
        run(tbl[v].n);
      end
      check($sformatf("vec%0d_kd", v), key_down, tbl[v].kd);
      check($sformatf("vec%0d_nev", v), got_q.size() - base,
            tbl[v].nev);
      if (tbl[v].nev > 0)
        check($sformatf("vec%0d_first", v), got_q[base],
              tbl[v].first);
      if (v == 5 && got_q.size() - base >= 2) begin
        check("dual_second", got_q[base+1], 5'b01_111);
        check("dual_gap", got_cyc[base+1] - got_cyc[base], 1);
      end
    end

    // overflow with consumer stalled
    do_reset();
    sb_on    = 1'b0;
    ev_ready = 1'b0;
    keys     = 8'h1F;
    run(3010);
    check("ovf_set", overflow, 1);
    check("ovf_valid", ev_valid, 1);
    check("ovf_head", ev_data, 5'b01_000);
    base     = got_q.size();
    ev_ready = 1'b1;
    run(10);
    check("ovf_kept", got_q.size() - base, 4);
    for (int j = 0; j < 4 && base + j < got_q.size(); j++)
      check($sformatf("ovf_order%0d", j), got_q[base+j],
            {2'b01, 3'(j)});
    check("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    cycle();
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // auto-repeat on key 3
    do_reset();
    sb_on    = 1'b1;
    ev_ready = 1'b1;
    keys     = 8'h08;
    run(3000);
    check("rep_accept", key_down, 8'h08);
    acc  = cyc;
    base = got_q.size();
    run(12000);
    nrep = 0;
    for (int j = base; j < got_q.size(); j++) begin
      if (got_q[j][4:3] == 2'b11) begin
        nrep++;
        rep_c.push_back(got_cyc[j]);
        check("rep_code", got_q[j], 5'b11_011);
      end
    end
`ifdef TM1638_KEY_REPEAT_EN
    check("rep_count", nrep, 4);
    for (int j = 0; j < 4 && j < rep_c.size(); j++)
      check($sformatf("rep_time%0d", j), rep_c[j],
            acc + (RD + j * RR) * 1000 + 1);
`else
    check("rep_none", nrep, 0);
`endif
    keys = 8'h00;
    run(4000);

    // reset while key 5 held and two events queued
    do_reset();
    sb_on    = 1'b0;
    ev_ready = 1'b0;
    keys     = 8'h60;
    run(3005);
    check("pre_rst_valid", ev_valid, 1);
    check("pre_rst_kd", key_down, 8'h60);
    do_reset();
    sb_on    = 1'b1;
    ev_ready = 1'b1;
    base     = got_q.size();
    run(2999);
    check("rst_repress_wait", key_down, 0);
    run(1);
    check("rst_repress", key_down, 8'h60);
    run(10);
    check("rst_nev", got_q.size() - base, 2);
    if (got_q.size() - base >= 2) begin
      check("rst_ev0", got_q[base], 5'b01_101);
      check("rst_ev1", got_q[base+1], 5'b01_110);
    end
    keys = 8'h00;
    run(4000);

    // random key patterns against the model
    do_reset();
    sb_on    = 1'b1;
    ev_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      keys = 8'($urandom) & 8'($urandom | $urandom);
      run($urandom_range(300, 2500));
    end
    keys = 8'h00;
    run(5000);
    check("sb_drain", exp_q.size(), 0);
    check("rand_idle", ev_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tm1638_key_events.md
TM1638_KEY_EVENTS -- requirements
Module: tm1638_key_events

Interface
REQ-001 SHALL have parameter clk_mhz, default 27, meaning system clock in MHz; 1 ms tick period = clk_mhz*1000 cycles.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, meaning consecutive ms ticks a raw key must differ from stable state before accepted (range 1..255).
REQ-003 SHALL have parameter REPEAT_DELAY_MS, default 500, meaning hold time from press to first REPEAT event.
REQ-004 SHALL have parameter REPEAT_RATE_MS, default 100, meaning interval between subsequent REPEAT events.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port keys  input  8  raw key levels from the board controller keys output, 1 = pressed.
REQ-009 SHALL have port key_down  output  8  debounced key levels.
REQ-010 SHALL have port ev_valid  output  1  event FIFO non-empty.
REQ-011 SHALL have port ev_ready  input  1  consumer accepts ev_data when ev_valid high.
REQ-012 SHALL have port ev_data  output  5  {kind[1:0], code[2:0]}; kind PRESS=01, RELEASE=10, REPEAT=11; code = key index 0..7.
REQ-013 SHALL have port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-014 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-015 SHALL generate a single-cycle ms_tick every clk_mhz*1000 cycles from a free-running divider; first tick clk_mhz*1000 cycles after reset release.
REQ-016 SHALL keep an 8-bit debounce counter per key: on ms_tick, increment if keys[i] != key_down[i], else clear; when it reaches DEBOUNCE_MS, key_down[i] toggles on that same clock edge and the counter clears.
REQ-017 SHALL set pending flag PRESS(i) or RELEASE(i) on the edge key_down[i] toggles; a toggle overwrites any unqueued pending flag of the same key.
REQ-018 SHALL enqueue at most one event per cycle, lowest key index first, the cycle after its pending flag is set at the earliest; the flag clears on enqueue.
REQ-019 SHALL implement FIFO as first-word-fall-through: ev_data valid while ev_valid=1; pop on ev_valid && ev_ready; ev_data held stable until popped.
REQ-020 SHALL, when full, accept simultaneous push and pop; push without pop when full drops the event, clears its pending flag, sets overflow.
REQ-021 SHALL clear overflow on overflow_clr; a drop in the same cycle as overflow_clr leaves overflow set.
REQ-022 SHALL never enqueue two events for the same key in the same cycle; order per key is preserved.

Reset
REQ-023 SHALL on rst clear key_down, debounce counters, tick divider, pending flags, repeat timers, FIFO pointers, ev_valid and overflow; ev_data = 0.
REQ-024 SHALL, on rst asserted mid-operation, discard all queued and pending events; no RELEASE events for keys held at reset.

Configuration
REQ-025 SHALL, with TM1638_KEY_REPEAT_EN defined, keep a per-key ms repeat timer: cleared on PRESS; first REPEAT(i) pending after REPEAT_DELAY_MS ticks held, then every REPEAT_RATE_MS; cleared on release.
REQ-026 SHALL, without TM1638_KEY_REPEAT_EN, emit no REPEAT events and instantiate no repeat timers; REPEAT_* parameters ignored.

Structure
REQ-027 SHALL place the ev_data struct typedef and kind encodings (PRESS, RELEASE, REPEAT) in shared package tm1638_pkg.
REQ-028 SHALL implement the event FIFO as sub-module tm1638_event_fifo (parameters width, depth; push/full, pop/empty).

Verification (clk_mhz=1, DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, ev_ready=1 unless stated)
REQ-029 SHALL cover: keys=8'h01 held 4000 cycles -> key_down[0]=1 at tick 3 (cycle 3000), exactly one event 5'b01_000.
REQ-030 SHALL cover: keys[2] glitch high for 1500 cycles then low -> key_down stays 0, no events.
REQ-031 SHALL cover: keys 8'h00->8'h81 in one cycle -> PRESS code 0 then PRESS code 7 on consecutive cycles.
REQ-032 SHALL cover: ev_ready=0, 5 press/release events -> first 4 retained in order, overflow=1; overflow_clr -> 0.
REQ-033 SHALL cover: with TM1638_KEY_REPEAT_EN, key 3 held 12 ms after accept -> REPEAT 5'b11_011 at +5, +7, +9, +11 ms; none without macro.
REQ-034 SHALL cover: rst pulsed while key 5 held with 2 events queued -> ev_valid=0, key_down=0 next cycle, re-press after DEBOUNCE_MS.
